// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end of the single-port RAM.
package spi_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = DATA_W + 2;

  // Frame command field, rx_data[FRAME_W-1 -: 2]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } spi_state_t;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises command+payload frames into rx_data with a one-cycle
// rx_valid strobe, and serialises the RAM's read byte onto MISO for read-data frames.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int unsigned FrameW = DATA_WIDTH + 2;
  localparam int unsigned CntW   = 4;

  // Counter encoding: 0..RxLast counts payload bits after the command bit,
  // RxDone means frame received, TxEnd means the read byte has been fully shifted.
  // While tx_phase_q is set the counter instead counts MISO bits already presented.
  localparam logic [CntW-1:0] RxLast = CntW'(DATA_WIDTH);
  localparam logic [CntW-1:0] RxDone = CntW'(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] TxBits = CntW'(DATA_WIDTH);
  localparam logic [CntW-1:0] TxEnd  = {CntW{1'b1}};

  spi_state_t             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [FrameW-2:0]      rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
  logic [FrameW-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   miso_q, miso_d;
  logic                   rd_addr_received_q, rd_addr_received_d;
  logic                   tx_phase_q, tx_phase_d;
  logic                   rx_active;

  assign rx_active = !tx_phase_q && (cnt_q <= RxLast);

  // Next-state and datapath updates for the frame FSM
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    rx_sr_d            = rx_sr_q;
    tx_sr_d            = tx_sr_q;
    rx_data_d          = rx_data_q;
    rx_valid_d         = 1'b0;
    miso_d             = miso_q;
    rd_addr_received_d = rd_addr_received_q;
    tx_phase_d         = tx_phase_q;

    if (state_q != StIdle && SS_n) begin
      // Frame aborted or finished by the master; partial frames never strobe.
      state_d    = StIdle;
      cnt_d      = '0;
      tx_phase_d = 1'b0;
      miso_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!SS_n) begin
            state_d = StChkCmd;
            cnt_d   = '0;
          end
        end

        StChkCmd: begin
          rx_sr_d = {rx_sr_q[FrameW-3:0], MOSI};
          if (!MOSI) begin
            state_d = StWrite;
          end else if (rd_addr_received_q) begin
            state_d = StReadData;
          end else begin
            state_d = StReadAdd;
          end
        end

        StWrite, StReadAdd, StReadData: begin
          if (rx_active) begin
            rx_sr_d = {rx_sr_q[FrameW-3:0], MOSI};
            if (cnt_q == RxLast) begin
              rx_data_d  = {rx_sr_q, MOSI};
              rx_valid_d = 1'b1;
              cnt_d      = RxDone;
              if (state_q == StReadAdd) begin
                rd_addr_received_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (state_q == StReadData) begin
            if (tx_phase_q) begin
              if (cnt_q == TxBits) begin
                miso_d             = 1'b0;
                tx_phase_d         = 1'b0;
                cnt_d              = TxEnd;
                rd_addr_received_d = 1'b0;
              end else begin
                miso_d  = tx_sr_q[DATA_WIDTH-1];
                tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
              end
            end else if (cnt_q == RxDone && !rx_valid_q && tx_valid) begin
              // First tx_valid after the strobe; later assertions are ignored
              // because the counter leaves RxDone for good.
              tx_phase_d = 1'b1;
              miso_d     = tx_data[DATA_WIDTH-1];
              tx_sr_d    = {tx_data[DATA_WIDTH-2:0], 1'b0};
              cnt_d      = CntW'(1);
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      rx_sr_q            <= '0;
      tx_sr_q            <= '0;
      rx_data_q          <= '0;
      rx_valid_q         <= 1'b0;
      miso_q             <= 1'b0;
      rd_addr_received_q <= 1'b0;
      tx_phase_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      rx_sr_q            <= rx_sr_d;
      tx_sr_q            <= tx_sr_d;
      rx_data_q          <= rx_data_d;
      rx_valid_q         <= rx_valid_d;
      miso_q             <= miso_d;
      rd_addr_received_q <= rd_addr_received_d;
      tx_phase_q         <= tx_phase_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
